// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: commits valE/valM to the 15-entry register file, serves the two decode read
// ports, and runs the RUN/STOP status FSM plus retired/cycle counters.
module wb_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter bit          BYPASS   = 1'b0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [1:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

    localparam logic [1:0]       STAT_AOK = 2'd0;
    localparam logic [3:0]       REG_NONE = 4'hF;
    localparam logic [3:0]       I_NOP    = 4'h1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       cpu_stat_q;
    logic [CNT_W-1:0] retired_q, cycle_q;
    logic [63:0]      regs_q [0:14];
    logic             running, commit;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // FSM: next state; STOP is absorbing until reset
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && W_stat != STAT_AOK) state_d = STOP;
    end

    // FSM: outputs
    always_comb begin
        running = (state_q == RUN);
        halted  = (state_q == STOP);
        commit  = running && (W_stat == STAT_AOK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_stat_q <= STAT_AOK;
            retired_q  <= '0;
            cycle_q    <= '0;
        end else if (running) begin
            cycle_q <= cycle_q + CNT_ONE;
            if (W_stat != STAT_AOK) cpu_stat_q <= W_stat;
            if (commit && W_icode != I_NOP) retired_q <= retired_q + CNT_ONE;
        end
    end

    // The dstM write is issued last so it wins when dstE == dstM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
        end else if (commit) begin
            if (W_dstE != REG_NONE) regs_q[W_dstE] <= W_valE;
            if (W_dstM != REG_NONE) regs_q[W_dstM] <= W_valM;
        end
    end

    function automatic logic [63:0] read_port(input logic [3:0] idx);
        logic [63:0] val;
        val = 64'h0;
        if (idx != REG_NONE) begin
            val = regs_q[idx];
            if (BYPASS && commit) begin
                if (idx == W_dstM)      val = W_valM;
                else if (idx == W_dstE) val = W_valE;
            end
        end
        return val;
    endfunction

    always_comb begin
        d_rvalA = read_port(d_srcA);
        d_rvalB = read_port(d_srcB);
    end

    assign cpu_stat    = cpu_stat_q;
    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
endmodule
